// File: rtl/sensor_averager_pkg.sv
// Shared definitions for the sensor averager: data width, channel count and
// channel indices, the sweep FSM encoding, and the sum-register width helper.
package sensor_averager_pkg;

   localparam int DATA_W   = 8;
   localparam int NUM_CHAN = 8;
   localparam int CHAN_W   = 3;

   // Channel order of one sensor sweep.
   localparam logic [CHAN_W-1:0] CH_SOLAR      = 3'd0;
   localparam logic [CHAN_W-1:0] CH_GREENHOUSE = 3'd1;
   localparam logic [CHAN_W-1:0] CH_AMBIENT    = 3'd2;
   localparam logic [CHAN_W-1:0] CH_GEOTHERMAL = 3'd3;
   localparam logic [CHAN_W-1:0] CH_N_LUX      = 3'd4;
   localparam logic [CHAN_W-1:0] CH_E_LUX      = 3'd5;
   localparam logic [CHAN_W-1:0] CH_S_LUX      = 3'd6;
   localparam logic [CHAN_W-1:0] CH_W_LUX      = 3'd7;
   localparam logic [CHAN_W-1:0] CH_LAST       = CH_W_LUX;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // A running sum of a full window of 8-bit samples needs log2(window)
   // extra bits so it can never wrap.
   function automatic int sum_width(input int depth_log2);
      return DATA_W + depth_log2;
   endfunction

endpackage

// File: rtl/sensor_averager_sample_history.sv
// sample_history: per-channel ring of the last 2^DEPTH_LOG2 samples.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears every entry)
//   chan      - channel select for both read and write
//   wptr      - ring slot for both read and write
//   rd_data   - combinational read of entry [chan][wptr] (the oldest sample)
//   wr_en     - write wr_data into entry [chan][wptr] at the clock edge
//   wr_data   - sample to store
module sample_history
   import sensor_averager_pkg::*;
#(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CHAN_W-1:0]     chan,
   input  logic [DEPTH_LOG2-1:0] wptr,
   output logic [DATA_W-1:0]     rd_data,
   input  logic                  wr_en,
   input  logic [DATA_W-1:0]     wr_data
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0] mem [NUM_CHAN][DEPTH];

   // Read-before-write on the same slot: the value read this cycle is the
   // one being evicted by the write at the edge.
   assign rd_data = mem[chan][wptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            for (int d = 0; d < DEPTH; d++) begin
               mem[c][d] <= '0;
            end
         end
      end else if (wr_en) begin
         mem[chan][wptr] <= wr_data;
      end
   end

endmodule

// File: rtl/sensor_averager.sv
// sensor_averager: moving average over 2^DEPTH_LOG2 sweeps for eight 8-bit
// sensor channels, processed one channel per cycle.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   sample_valid              - one-cycle pulse: all eight inputs hold a sweep
//   *_celcius, *_lux          - raw readings, channels 0..7
//   avg_*                     - windowed averages (floor), stable between updates
//   avg_valid                 - one-cycle pulse: all averages just updated
//   primed                    - a full window of sweeps has been accumulated
//   overrun                   - one-cycle pulse: a sample_valid was dropped
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for sample_valid; captures the snapshot on accept
// ST_ACCUM | updates one channel's running sum per cycle, chan 0..7
// ST_DONE  | loads all averages, pulses avg_valid, advances wptr
module sensor_averager
   import sensor_averager_pkg::*;
#(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] solar_celcius,
   input  logic [DATA_W-1:0] greenhouse_celcius,
   input  logic [DATA_W-1:0] ambient_celcius,
   input  logic [DATA_W-1:0] geothermal_celcius,
   input  logic [DATA_W-1:0] n_lux,
   input  logic [DATA_W-1:0] e_lux,
   input  logic [DATA_W-1:0] s_lux,
   input  logic [DATA_W-1:0] w_lux,
   output logic [DATA_W-1:0] avg_solar,
   output logic [DATA_W-1:0] avg_greenhouse,
   output logic [DATA_W-1:0] avg_ambient,
   output logic [DATA_W-1:0] avg_geothermal,
   output logic [DATA_W-1:0] avg_n,
   output logic [DATA_W-1:0] avg_e,
   output logic [DATA_W-1:0] avg_s,
   output logic [DATA_W-1:0] avg_w,
   output logic              avg_valid,
   output logic              primed,
   output logic              overrun
);

   localparam int SUM_W  = sum_width(DEPTH_LOG2);
   localparam int CNT_W  = DEPTH_LOG2 + 1;
   localparam int WINDOW = 1 << DEPTH_LOG2;

   state_t state, next_state;

   logic                  capture;
   logic                  accum_en;
   logic                  done_en;
   logic                  overrun_set;

   logic [CHAN_W-1:0]     chan;
   logic [DEPTH_LOG2-1:0] wptr;
   logic [CNT_W-1:0]      sweep_cnt;

   logic [DATA_W-1:0]     raw  [NUM_CHAN];
   logic [DATA_W-1:0]     snap [NUM_CHAN];
   logic [SUM_W-1:0]      sum  [NUM_CHAN];
   logic [DATA_W-1:0]     avg  [NUM_CHAN];
   logic [DATA_W-1:0]     hist_rd;

   always_comb begin
      raw[CH_SOLAR]      = solar_celcius;
      raw[CH_GREENHOUSE] = greenhouse_celcius;
      raw[CH_AMBIENT]    = ambient_celcius;
      raw[CH_GEOTHERMAL] = geothermal_celcius;
      raw[CH_N_LUX]      = n_lux;
      raw[CH_E_LUX]      = e_lux;
      raw[CH_S_LUX]      = s_lux;
      raw[CH_W_LUX]      = w_lux;
   end

   sample_history #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_history (
      .clk     (clk),
      .rst     (rst),
      .chan    (chan),
      .wptr    (wptr),
      .rd_data (hist_rd),
      .wr_en   (accum_en),
      .wr_data (snap[chan])
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      capture     = 1'b0;
      accum_en    = 1'b0;
      done_en     = 1'b0;
      overrun_set = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (sample_valid) begin
               capture    = 1'b1;
               next_state = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            accum_en    = 1'b1;
            overrun_set = sample_valid;
            if (chan == CH_LAST) begin
               next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            done_en     = 1'b1;
            overrun_set = sample_valid;
            next_state  = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chan      <= '0;
         wptr      <= '0;
         sweep_cnt <= '0;
         avg_valid <= 1'b0;
         primed    <= 1'b0;
         overrun   <= 1'b0;
         for (int c = 0; c < NUM_CHAN; c++) begin
            snap[c] <= '0;
            sum[c]  <= '0;
            avg[c]  <= '0;
         end
      end else begin
         avg_valid <= 1'b0;
         overrun   <= overrun_set;

         if (capture) begin
            chan <= '0;
            for (int c = 0; c < NUM_CHAN; c++) begin
               snap[c] <= raw[c];
            end
         end

         // Subtract the evicted sample before adding the new one; the sum
         // always contains the evicted sample, so neither step can wrap.
         if (accum_en) begin
            sum[chan] <= sum[chan] - SUM_W'(hist_rd) + SUM_W'(snap[chan]);
            chan      <= chan + CHAN_W'(1);
         end

         if (done_en) begin
            avg_valid <= 1'b1;
            wptr      <= wptr + DEPTH_LOG2'(1);
            for (int c = 0; c < NUM_CHAN; c++) begin
               avg[c] <= sum[c][SUM_W-1:DEPTH_LOG2];
            end
            if (sweep_cnt != CNT_W'(WINDOW)) begin
               sweep_cnt <= sweep_cnt + CNT_W'(1);
            end
            if (sweep_cnt == CNT_W'(WINDOW - 1)) begin
               primed <= 1'b1;
            end
         end
      end
   end

   assign avg_solar      = avg[CH_SOLAR];
   assign avg_greenhouse = avg[CH_GREENHOUSE];
   assign avg_ambient    = avg[CH_AMBIENT];
   assign avg_geothermal = avg[CH_GEOTHERMAL];
   assign avg_n          = avg[CH_N_LUX];
   assign avg_e          = avg[CH_E_LUX];
   assign avg_s          = avg[CH_S_LUX];
   assign avg_w          = avg[CH_W_LUX];

endmodule

// File: doc/sensor_averager.md
SENSOR_AVERAGER -- requirements
Module: sensor_averager

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 2: log2 of the moving-average window (window = 4 sweeps).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port sample_valid, input, 1: one-cycle pulse marking that all eight sensor inputs hold a completed sweep.
REQ-005 SHALL have ports solar_celcius, greenhouse_celcius, ambient_celcius, geothermal_celcius, n_lux, e_lux, s_lux, w_lux, each input, 8, unsigned: raw readings, channels 0..7 in that order.
REQ-006 SHALL have ports avg_solar, avg_greenhouse, avg_ambient, avg_geothermal, avg_n, avg_e, avg_s, avg_w, each output, 8, unsigned: windowed averages, channels 0..7.
REQ-007 SHALL have port avg_valid, output, 1: one-cycle pulse marking that all eight averages have just updated.
REQ-008 SHALL have port primed, output, 1: high once at least 2^DEPTH_LOG2 sweeps have been accumulated since reset.
REQ-009 SHALL have port overrun, output, 1: one-cycle pulse when a sample_valid is dropped.

Function
REQ-010 SHALL implement an FSM with states IDLE, ACCUM and DONE.
REQ-011 In IDLE with sample_valid=1: all 8 inputs SHALL be captured into snapshot registers, chan set to 0, next state ACCUM.
REQ-012 In ACCUM, each cycle SHALL process exactly one channel (chan): sum[chan] <= sum[chan] - hist[chan][wptr] + snap[chan]; hist[chan][wptr] <= snap[chan]; chan increments.
REQ-013 After channel 7 is processed, the FSM SHALL enter DONE; chan wraps to 0.
REQ-014 In DONE, all eight avg outputs SHALL load sum[ch] >> DEPTH_LOG2 simultaneously; avg_valid=1 for one cycle; wptr increments modulo 2^DEPTH_LOG2; next state IDLE.
REQ-015 Latency: with sample_valid sampled at edge T, avg_valid SHALL be high during the cycle following edge T+9; back-to-back sweeps are accepted every 10 cycles.
REQ-016 Each sum register SHALL be 8+DEPTH_LOG2 bits wide; the update SHALL never overflow or underflow (max 255 x window).
REQ-017 Averages SHALL be truncated (floor), not rounded.
REQ-018 sample_valid arriving in ACCUM or DONE SHALL be ignored (snapshot unchanged) and SHALL pulse overrun in the following cycle.
REQ-019 A sweep counter SHALL saturate at 2^DEPTH_LOG2; primed SHALL rise in the same cycle as the avg_valid of the window-th sweep and stay high until reset.
REQ-020 Before priming, averages SHALL still be produced, with empty history slots counted as 0.
REQ-021 avg outputs SHALL remain stable between avg_valid pulses.

Reset
REQ-022 On rst=1 at a clock edge: state IDLE, chan=0, wptr=0, sweep counter 0, all sums, history entries, snapshots and avg outputs 0; avg_valid, primed and overrun 0.
REQ-023 rst SHALL take priority over sample_valid and over an in-progress sweep; a partial sweep SHALL be discarded, with no avg_valid.

Structure
REQ-024 A shared package/header SHALL hold the channel indices 0..7, the FSM state encoding and the sensor data width (8).
REQ-025 The per-channel history SHALL be a sub-module sample_history (8 channels x 2^DEPTH_LOG2 x 8 bits, one read and one write port addressed by chan and wptr).

Verification
REQ-026 After reset, one sweep with all inputs 100 -> avg_valid 9 cycles after the sample_valid cycle, all averages 25, primed=0.
REQ-027 Four sweeps with solar 10, 20, 30, 40 -> avg_solar 2, 7, 15, 25; primed=1 on the fourth avg_valid.
REQ-028 Fifth sweep, solar 200, after REQ-027 -> avg_solar (20+30+40+200)/4=72 (oldest value evicted).
REQ-029 All inputs 255 for 6 sweeps -> all averages 255, no wrap; primed=1.
REQ-030 sample_valid reasserted 3 cycles after an accepted one -> overrun pulses once; snapshot unchanged; the in-flight sweep completes normally.
REQ-031 rst asserted at chan=4 mid-ACCUM -> no avg_valid; all outputs 0; the next sweep of 80s gives averages 20.
